pq_bank_buffer: RTL and testbench
=================================

PQ_BANK_BUFFER -- requirements
Module: pq_bank_buffer

Interface
REQ-001 SHALL have parameter WORDLENGTH, default 32, data word width.
REQ-002 SHALL have parameter ADDRLENGTH, default 12, per-bank address width; bank depth 2^ADDRLENGTH.
REQ-003 SHALL have parameter NBANK, default 2, bank count, legal 2..4.
REQ-004 SHALL have parameter ADDRWDELAY, default 10, write-address delay in enabled cycles, legal 0..15.
REQ-005 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port enable, input, 1, global clock-enable.
REQ-008 SHALL have port wr_valid, input, 1, write strobe for wr_data this cycle.
REQ-009 SHALL have port wr_addr, input, ADDRLENGTH, write address, issued ADDRWDELAY enabled cycles before its data.
REQ-010 SHALL have port wr_data, input, WORDLENGTH, write data.
REQ-011 SHALL have port wr_last, input, 1, qualifies wr_valid; marks final word of the bank (commit).
REQ-012 SHALL have port rd_en, input, 1, read request.
REQ-013 SHALL have port rd_addr, input, ADDRLENGTH, read address.
REQ-014 SHALL have port rd_done, input, 1, releases current read bank.
REQ-015 SHALL have port rd_data, output, WORDLENGTH, registered read data.
REQ-016 SHALL have port rd_valid, output, 1, rd_data valid.
REQ-017 SHALL have port wr_rdy, output, 1, a bank is available for writing.
REQ-018 SHALL have port rd_rdy, output, 1, a committed bank is available for reading.
REQ-019 SHALL have ports wr_bank and rd_bank, output, 2 bits each, current write and read bank indices.
REQ-020 SHALL have port overflow, output, 1, sticky dropped-write flag.

Function
REQ-021 SHALL store NBANK x 2^ADDRLENGTH words; synchronous write; registered read; contents not reset.
REQ-022 SHALL delay wr_addr through an ADDRWDELAY-stage register line advancing only when enable=1; ADDRWDELAY=0 means undelayed.
REQ-023 SHALL maintain wp, rp (0..NBANK-1) and occ (0..NBANK) counting committed, unreleased banks.
REQ-024 SHALL drive wr_rdy = (occ<NBANK), rd_rdy = (occ>0), wr_bank = wp, rd_bank = rp.
REQ-025 SHALL write wr_data to bank wp at the delayed address when enable, wr_valid and wr_rdy are all 1.
REQ-026 SHALL, when wr_valid=1 and wr_rdy=0 with enable=1, drop the write, hold wp/occ and set overflow until reset.
REQ-027 SHALL, on an accepted write with wr_last=1, advance wp modulo NBANK and increment occ.
REQ-028 SHALL, when rd_en=1, rd_rdy=1 and enable=1, load rd_data from bank rp at rd_addr and assert rd_valid the next cycle (latency 1).
REQ-029 SHALL, when rd_en=1 and rd_rdy=0, ignore the read: rd_valid=0 next cycle, rd_data holds.
REQ-030 SHALL deassert rd_valid the cycle after any enabled cycle with no accepted read.
REQ-031 SHALL, when rd_done=1, rd_rdy=1 and enable=1, advance rp modulo NBANK and decrement occ; rd_done with rd_rdy=0 ignored.
REQ-032 SHALL, on simultaneous commit and release, advance both pointers and leave occ unchanged.
REQ-033 SHALL apply a same-cycle read to the pre-release bank rp.
REQ-034 SHALL, when enable=0, freeze delay line, pointers, occ, memory, rd_data and rd_valid.
REQ-035 SHALL never write the bank currently being read (guaranteed by wp==rp only when occ is 0 or NBANK).

Reset
REQ-036 SHALL, on rst=0, immediately clear wp, rp, occ, delay line, rd_data, rd_valid and overflow; wr_rdy=1, rd_rdy=0.
REQ-037 SHALL abandon a partially filled bank on reset mid-operation; its data is not readable.

Verification (NBANK=2, ADDRLENGTH=4, ADDRWDELAY=2, WORDLENGTH=8)
REQ-038 SHALL cover: wr_addr 0..15 at cycles t..t+15, wr_data 0xA0..0xAF with wr_valid at t+2..t+17, wr_last at t+17 -> occ=1, wr_bank=1; rd_addr 5 -> rd_data=0xA5 one cycle later.
REQ-039 SHALL cover: fill both banks -> wr_rdy=0; extra wr_valid -> overflow=1, memory unchanged; rd_done -> wr_rdy=1, rd_bank=1.
REQ-040 SHALL cover: rd_en with occ=0 -> rd_valid=0, rd_data unchanged.
REQ-041 SHALL cover: commit and rd_done same cycle with occ=1 -> occ=1, wp and rp both advance.
REQ-042 SHALL cover: enable=0 for 5 cycles mid-fill -> no writes, no delay-line shift; resume yields correct address/data pairing.
REQ-043 SHALL cover: rst=0 mid-fill and mid-read -> all outputs at reset values within same cycle, overflow cleared.

Source files
------------

// File: rtl/pq_bank_buffer.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | pq_bank_buffer: NBANK-deep ping-pong bank buffer with delayed write addr.  |
// | Revision: 1.0                                                              |
// +---------------------------------------------------------------------------+
module pq_bank_buffer #(
  parameter int WORDLENGTH = 32,
  parameter int ADDRLENGTH = 12,
  parameter int NBANK      = 2,
  parameter int ADDRWDELAY = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  wr_valid,
  input  logic [ADDRLENGTH-1:0] wr_addr,
  input  logic [WORDLENGTH-1:0] wr_data,
  input  logic                  wr_last,
  input  logic                  rd_en,
  input  logic [ADDRLENGTH-1:0] rd_addr,
  input  logic                  rd_done,
  output logic [WORDLENGTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  wr_rdy,
  output logic                  rd_rdy,
  output logic [1:0]            wr_bank,
  output logic [1:0]            rd_bank,
  output logic                  overflow
);

  localparam int         DEPTH    = 1 << ADDRLENGTH;
  localparam int         BANKW    = (NBANK > 2) ? 2 : 1;
  localparam logic [2:0] NBANK_C  = 3'(NBANK);
  localparam logic [1:0] LAST_PTR = 2'(NBANK - 1);

  logic [WORDLENGTH-1:0] mem [0:NBANK*DEPTH-1];

  logic [1:0]            wp_q, wp_d;
  logic [1:0]            rp_q, rp_d;
  logic [2:0]            occ_q, occ_d;
  logic [WORDLENGTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  overflow_q, overflow_d;

  logic [ADDRLENGTH-1:0] wr_addr_dly;
  logic                  wr_accept;
  logic                  commit;
  logic                  release_bank;
  logic                  rd_accept;

  // Write address travels through a line that only shifts on enabled cycles,
  // so address/data pairing survives enable gaps.
  generate
    if (ADDRWDELAY == 0) begin : g_no_delay
      assign wr_addr_dly = wr_addr;
    end else begin : g_delay
      logic [ADDRLENGTH-1:0] addr_dly_q [0:ADDRWDELAY-1];
      logic [ADDRLENGTH-1:0] addr_dly_d [0:ADDRWDELAY-1];

      always_comb begin
        for (int i = 0; i < ADDRWDELAY; i++) begin
          addr_dly_d[i] = addr_dly_q[i];
        end
        if (enable) begin
          addr_dly_d[0] = wr_addr;
          for (int i = 1; i < ADDRWDELAY; i++) begin
            addr_dly_d[i] = addr_dly_q[i-1];
          end
        end
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int i = 0; i < ADDRWDELAY; i++) begin
            addr_dly_q[i] <= '0;
          end
        end else begin
          for (int i = 0; i < ADDRWDELAY; i++) begin
            addr_dly_q[i] <= addr_dly_d[i];
          end
        end
      end

      assign wr_addr_dly = addr_dly_q[ADDRWDELAY-1];
    end
  endgenerate

  assign wr_rdy   = (occ_q < NBANK_C);
  assign rd_rdy   = (occ_q != 3'd0);
  assign wr_bank  = wp_q;
  assign rd_bank  = rp_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign overflow = overflow_q;

  assign wr_accept    = enable & wr_valid & wr_rdy;
  assign commit       = wr_accept & wr_last;
  assign release_bank = enable & rd_done & rd_rdy;
  assign rd_accept    = enable & rd_en & rd_rdy;

  always_comb begin
    wp_d       = wp_q;
    rp_d       = rp_q;
    occ_d      = occ_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_valid_q;
    overflow_d = overflow_q;

    if (enable) begin
      if (commit) begin
        wp_d = (wp_q == LAST_PTR) ? 2'd0 : wp_q + 2'd1;
      end
      if (release_bank) begin
        rp_d = (rp_q == LAST_PTR) ? 2'd0 : rp_q + 2'd1;
      end
      case ({commit, release_bank})
        2'b10:   occ_d = occ_q + 3'd1;
        2'b01:   occ_d = occ_q - 3'd1;
        default: occ_d = occ_q;
      endcase

      if (wr_valid && !wr_rdy) begin
        overflow_d = 1'b1;
      end

      // A read in the same cycle as a release still sees the old rp.
      rd_valid_d = rd_accept;
      if (rd_accept) begin
        rd_data_d = mem[{rp_q[BANKW-1:0], rd_addr}];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp_q       <= '0;
      rp_q       <= '0;
      occ_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      occ_q      <= occ_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[{wp_q[BANKW-1:0], wr_addr_dly}] <= wr_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pq_bank_buffer.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_pq_bank_buffer: directed self-checking bench, 2 banks x 16 x 8 bits.    |
// | Revision: 1.0                                                              |
// +---------------------------------------------------------------------------+
module tb_pq_bank_buffer;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       wr_valid;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_last;
  logic       rd_en;
  logic [3:0] rd_addr;
  logic       rd_done;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       wr_rdy;
  logic       rd_rdy;
  logic [1:0] wr_bank;
  logic [1:0] rd_bank;
  logic       overflow;

  int tests  = 0;
  int failed = 0;

  pq_bank_buffer #(
    .WORDLENGTH(8),
    .ADDRLENGTH(4),
    .NBANK(2),
    .ADDRWDELAY(2)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_last(wr_last),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_done(rd_done),
    .rd_data(rd_data), .rd_valid(rd_valid), .wr_rdy(wr_rdy), .rd_rdy(rd_rdy),
    .wr_bank(wr_bank), .rd_bank(rd_bank), .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0; wr_last = 1'b0;
    rd_en = 1'b0; rd_addr = '0; rd_done = 1'b0;
  endtask

  // Addresses 0..15 at cycles 0..15, data base+0..base+15 at cycles 2..17,
  // wr_last on cycle 17; optional 5-cycle enable=0 gap before cycle pause_at.
  task automatic fill_bank(input logic [7:0] base, input int pause_at,
                           input logic done_last, input logic rd_last,
                           input logic [3:0] rd_a);
    for (int c = 0; c < 18; c++) begin
      if (c == pause_at) begin
        enable = 1'b0; wr_valid = 1'b1; wr_addr = 4'hF; wr_data = 8'hFF; wr_last = 1'b1;
        repeat (5) tick();
        enable = 1'b1;
      end
      wr_addr  = (c < 16) ? 4'(c) : 4'h0;
      wr_valid = (c >= 2);
      wr_data  = base + 8'(c - 2);
      wr_last  = (c == 17);
      rd_done  = (c == 17) && done_last;
      rd_en    = (c == 17) && rd_last;
      rd_addr  = rd_a;
      tick();
    end
    idle_inputs();
  endtask

  task automatic do_read(input logic [3:0] a);
    rd_en = 1'b1; rd_addr = a;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; enable = 1'b1; idle_inputs();
    repeat (2) tick();
    tests++; if (wr_rdy !== 1'b1) begin failed++; $display("FAIL reset_wr_rdy: got %b exp 1", wr_rdy); end
    tests++; if (rd_rdy !== 1'b0) begin failed++; $display("FAIL reset_rd_rdy: got %b exp 0", rd_rdy); end
    tests++; if (rd_valid !== 1'b0) begin failed++; $display("FAIL reset_rd_valid: got %b exp 0", rd_valid); end
    tests++; if (rd_data !== 8'h00) begin failed++; $display("FAIL reset_rd_data: got %h exp 00", rd_data); end
    tests++; if (overflow !== 1'b0) begin failed++; $display("FAIL reset_overflow: got %b exp 0", overflow); end
    tests++; if ({wr_bank, rd_bank} !== 4'b0000) begin failed++; $display("FAIL reset_banks: got %b/%b exp 00/00", wr_bank, rd_bank); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_basic_fill();
    fill_bank(8'hA0, -1, 1'b0, 1'b0, 4'h0);
    tests++; if (wr_bank !== 2'd1) begin failed++; $display("FAIL fill_wr_bank: got %0d exp 1", wr_bank); end
    tests++; if (rd_rdy !== 1'b1 || wr_rdy !== 1'b1) begin failed++; $display("FAIL fill_rdy: got rd %b wr %b exp 1 1", rd_rdy, wr_rdy); end
    do_read(4'd5);
    tests++; if (rd_valid !== 1'b1 || rd_data !== 8'hA5) begin failed++; $display("FAIL read_a5: got v=%b %h exp v=1 a5", rd_valid, rd_data); end
    do_read(4'd15);
    tests++; if (rd_data !== 8'hAF) begin failed++; $display("FAIL read_af: got %h exp af", rd_data); end
    do_read(4'd0);
    tests++; if (rd_data !== 8'hA0) begin failed++; $display("FAIL read_a0: got %h exp a0", rd_data); end
    tick();
    tests++; if (rd_valid !== 1'b0 || rd_data !== 8'hA0) begin failed++; $display("FAIL read_idle: got v=%b %h exp v=0 a0", rd_valid, rd_data); end
  endtask

  task automatic test_overflow();
    fill_bank(8'hB0, -1, 1'b0, 1'b0, 4'h0);
    tests++; if (wr_rdy !== 1'b0 || wr_bank !== 2'd0) begin failed++; $display("FAIL full_state: got wr_rdy %b wr_bank %0d exp 0 0", wr_rdy, wr_bank); end
    tests++; if (overflow !== 1'b0) begin failed++; $display("FAIL pre_overflow: got %b exp 0", overflow); end
    wr_valid = 1'b1; wr_data = 8'hEE; wr_last = 1'b1;
    tick();
    idle_inputs();
    tests++; if (overflow !== 1'b1 || wr_bank !== 2'd0) begin failed++; $display("FAIL overflow: got ovf %b wr_bank %0d exp 1 0", overflow, wr_bank); end
    do_read(4'd0);
    tests++; if (rd_data !== 8'hA0) begin failed++; $display("FAIL dropped_write: got %h exp a0", rd_data); end
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
    tests++; if (wr_rdy !== 1'b1 || rd_bank !== 2'd1 || rd_rdy !== 1'b1) begin failed++; $display("FAIL release1: got wr_rdy %b rd_bank %0d rd_rdy %b exp 1 1 1", wr_rdy, rd_bank, rd_rdy); end
    do_read(4'd3);
    tests++; if (rd_data !== 8'hB3) begin failed++; $display("FAIL read_b3: got %h exp b3", rd_data); end
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
    tests++; if (rd_rdy !== 1'b0 || rd_bank !== 2'd0) begin failed++; $display("FAIL release2: got rd_rdy %b rd_bank %0d exp 0 0", rd_rdy, rd_bank); end
    tests++; if (overflow !== 1'b1) begin failed++; $display("FAIL overflow_sticky: got %b exp 1", overflow); end
  endtask

  task automatic test_read_empty();
    do_read(4'd7);
    tests++; if (rd_valid !== 1'b0 || rd_data !== 8'hB3) begin failed++; $display("FAIL read_empty: got v=%b %h exp v=0 b3", rd_valid, rd_data); end
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
    tests++; if (rd_bank !== 2'd0 || rd_rdy !== 1'b0) begin failed++; $display("FAIL done_empty: got rd_bank %0d rd_rdy %b exp 0 0", rd_bank, rd_rdy); end
  endtask

  task automatic test_back_to_back();
    fill_bank(8'hC0, -1, 1'b0, 1'b0, 4'h0);
    fill_bank(8'hD0, -1, 1'b1, 1'b1, 4'd2);
    tests++; if (wr_bank !== 2'd0 || rd_bank !== 2'd1) begin failed++; $display("FAIL commit_release_ptr: got wp %0d rp %0d exp 0 1", wr_bank, rd_bank); end
    tests++; if (wr_rdy !== 1'b1 || rd_rdy !== 1'b1) begin failed++; $display("FAIL commit_release_occ: got wr_rdy %b rd_rdy %b exp 1 1", wr_rdy, rd_rdy); end
    tests++; if (rd_valid !== 1'b1 || rd_data !== 8'hC2) begin failed++; $display("FAIL read_pre_release: got v=%b %h exp v=1 c2", rd_valid, rd_data); end
    do_read(4'd9);
    tests++; if (rd_data !== 8'hD9) begin failed++; $display("FAIL read_d9: got %h exp d9", rd_data); end
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
    tests++; if (rd_rdy !== 1'b0 || rd_bank !== 2'd0) begin failed++; $display("FAIL drain: got rd_rdy %b rd_bank %0d exp 0 0", rd_rdy, rd_bank); end
  endtask

  task automatic test_enable_freeze();
    fill_bank(8'hE0, 8, 1'b0, 1'b0, 4'h0);
    tests++; if (wr_bank !== 2'd1 || rd_rdy !== 1'b1) begin failed++; $display("FAIL pause_commit: got wr_bank %0d rd_rdy %b exp 1 1", wr_bank, rd_rdy); end
    do_read(4'd6);
    tests++; if (rd_data !== 8'hE6) begin failed++; $display("FAIL pause_e6: got %h exp e6", rd_data); end
    do_read(4'd8);
    tests++; if (rd_data !== 8'hE8) begin failed++; $display("FAIL pause_e8: got %h exp e8", rd_data); end
    do_read(4'd9);
    tests++; if (rd_data !== 8'hE9) begin failed++; $display("FAIL pause_e9: got %h exp e9", rd_data); end
    do_read(4'd15);
    tests++; if (rd_data !== 8'hEF) begin failed++; $display("FAIL pause_ef: got %h exp ef", rd_data); end
    enable = 1'b0; rd_en = 1'b1; rd_addr = 4'd7; rd_done = 1'b1;
    repeat (2) tick();
    tests++; if (rd_valid !== 1'b1 || rd_data !== 8'hEF) begin failed++; $display("FAIL freeze_rd: got v=%b %h exp v=1 ef", rd_valid, rd_data); end
    tests++; if (rd_bank !== 2'd0 || rd_rdy !== 1'b1) begin failed++; $display("FAIL freeze_ptr: got rd_bank %0d rd_rdy %b exp 0 1", rd_bank, rd_rdy); end
    idle_inputs(); enable = 1'b1;
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 8; c++) begin
      wr_addr = 4'(c); wr_valid = (c >= 2); wr_data = 8'h50 + 8'(c); rd_en = 1'b1; rd_addr = 4'd3;
      tick();
    end
    tests++; if (rd_valid !== 1'b1 || rd_data !== 8'hE3 || overflow !== 1'b1) begin failed++; $display("FAIL pre_rst: got v=%b %h ovf %b exp v=1 e3 1", rd_valid, rd_data, overflow); end
    #2 rst = 1'b0;
    #1;
    tests++; if (rd_valid !== 1'b0 || rd_data !== 8'h00 || overflow !== 1'b0) begin failed++; $display("FAIL async_rst_data: got v=%b %h ovf %b exp v=0 00 0", rd_valid, rd_data, overflow); end
    tests++; if (wr_rdy !== 1'b1 || rd_rdy !== 1'b0 || wr_bank !== 2'd0 || rd_bank !== 2'd0) begin failed++; $display("FAIL async_rst_ctrl: got %b %b %0d %0d exp 1 0 0 0", wr_rdy, rd_rdy, wr_bank, rd_bank); end
    idle_inputs();
    #2 rst = 1'b1;
    do_read(4'd3);
    tests++; if (rd_valid !== 1'b0 || rd_rdy !== 1'b0) begin failed++; $display("FAIL abandoned: got v=%b rd_rdy %b exp 0 0", rd_valid, rd_rdy); end
  endtask

  initial begin
    test_reset();
    test_basic_fill();
    test_overflow();
    test_read_empty();
    test_back_to_back();
    test_enable_freeze();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
